// File: rtl/wb_regfile_unit.sv
// -----------------------------------------------------------------------------
// wb_regfile_unit
//   Write-back stage and 32x64 vector register file. Consumes ALU results
//   (ALU_output / ALU_rD / ALU_PPP) and commits the bytes selected by the PPP
//   participation field. Serves two registered read ports (rA, rB) to ID.
//   Bit numbering is big-endian [0:63]; byte k occupies bits [8k:8k+7].
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : a same-edge read of the register being written returns the
//               merged word (new bytes under the mask, old bytes elsewhere).
//   undefined : such a read returns the pre-write contents; ID must insert a
//               bubble for a read-after-write at distance 0.
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   WB_enable       ALU result valid this cycle (always accepted, no stall)
//   ALU_rD          destination register
//   ALU_PPP         participation field -> byte mask
//   ALU_output      result data [0:63]
//   RD_enable       sample ID_rA / ID_rB at this edge
//   ID_rA, ID_rB    read addresses
//   RF_rA_data      registered read data A (holds while RD_enable=0)
//   RF_rB_data      registered read data B (holds while RD_enable=0)
//   WB_byte_mask    mask applied at the last edge, 0 when no effective write
//   WB_commit_cnt   effective writes since reset, saturating
//
// Handshake: none. WB_enable is a one-cycle valid with an implicit, always
// asserted ready; every presented result is consumed at the next edge.
// -----------------------------------------------------------------------------
module wb_regfile_unit #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WB_enable,
    input  logic [ADDR_W-1:0] ALU_rD,
    input  logic [2:0]        ALU_PPP,
    input  logic [0:DATA_W-1] ALU_output,
    input  logic              RD_enable,
    input  logic [ADDR_W-1:0] ID_rA,
    input  logic [ADDR_W-1:0] ID_rB,
    output logic [0:DATA_W-1] RF_rA_data,
    output logic [0:DATA_W-1] RF_rB_data,
    output logic [0:7]        WB_byte_mask,
    output logic [CNT_W-1:0]  WB_commit_cnt
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [0:DATA_W-1] regs_q [NREGS];
    logic [0:DATA_W-1] rf_a_q, rf_a_d;
    logic [0:DATA_W-1] rf_b_q, rf_b_d;
    logic [0:7]        mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [0:7]        ppp_mask;
    logic              wr_eff;
    logic [0:DATA_W-1] merged;

    // PPP decode; reserved codes select no bytes, which suppresses the write.
    always_comb begin
        ppp_mask = 8'b0000_0000;
        case (ALU_PPP)
            3'b000:  ppp_mask = 8'b1111_1111;
            3'b001:  ppp_mask = 8'b1111_0000;
            3'b010:  ppp_mask = 8'b0000_1111;
            3'b011:  ppp_mask = 8'b1010_1010;
            3'b100:  ppp_mask = 8'b0101_0101;
            default: ppp_mask = 8'b0000_0000;
        endcase
    end

    assign wr_eff = WB_enable && (ALU_rD != '0) && (ppp_mask != 8'h00);

    // Byte merge of the new result over the current register contents.
    always_comb begin
        merged = regs_q[ALU_rD];
        for (int k = 0; k < 8; k++) begin
            if (ppp_mask[k]) merged[8*k +: 8] = ALU_output[8*k +: 8];
        end
    end

    always_comb begin
        rf_a_d = rf_a_q;
        rf_b_d = rf_b_q;
        if (RD_enable) begin
            rf_a_d = regs_q[ID_rA];
            rf_b_d = regs_q[ID_rB];
`ifdef WB_BYPASS_EN
            if (wr_eff && (ID_rA == ALU_rD)) rf_a_d = merged;
            if (wr_eff && (ID_rB == ALU_rD)) rf_b_d = merged;
`endif
        end
    end

    always_comb begin
        mask_d = wr_eff ? ppp_mask : 8'h00;
        cnt_d  = cnt_q;
        if (wr_eff && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    // R0 is only ever cleared by reset and never written, so it reads 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            rf_a_q <= '0;
            rf_b_q <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_eff) regs_q[ALU_rD] <= merged;
            rf_a_q <= rf_a_d;
            rf_b_q <= rf_b_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
        end
    end

    assign RF_rA_data    = rf_a_q;
    assign RF_rB_data    = rf_b_q;
    assign WB_byte_mask  = mask_q;
    assign WB_commit_cnt = cnt_q;

endmodule
